// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Round-robin arbiter and access sequencer for the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 is the loader/debug port. Each granted
// access takes IDLE -> ACCESS -> RESP, and RESP carries the one-cycle Ack.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in flight; arbitrate and latch the winner's request
// ACCESS | memory enables driven from the latched request; result registered
// RESP   | Ack pulse to the granted port; RData/Err valid
module data_mem_arbiter #(
    parameter int DEPTH = 128,
    parameter int IDX_W = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Write0,
    input  logic        Write1,
    input  logic [31:0] Addr0,
    input  logic [31:0] Addr1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [31:0] RData,
    output logic        Err,
    output logic        Busy,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    // Byte addresses at or above this limit fall outside the memory.
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;  // port granted most recently; the other wins a tie
    logic        gnt_id;      // port owning the access in flight
    logic        lat_legal;   // latched request passed the alignment/range check
    logic        mem_rd_q;
    logic        mem_wr_q;

    logic        win;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;

    // Pick the winning port and pre-check its address before it is latched.
    always_comb begin
        win = 1'b0;
        if (Req0 && Req1) begin
            win = ~last_grant;
        end else if (Req1) begin
            win = 1'b1;
        end
        sel_write = win ? Write1 : Write0;
        sel_addr  = win ? Addr1  : Addr0;
        sel_wdata = win ? WData1 : WData0;
        // The full 32-bit compare keeps high address bits from aliasing onto a valid index.
        sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_LIMIT);
    end

    // Sequencer: arbitration, latching, result capture and Ack generation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            last_grant   <= 1'b1;
            gnt_id       <= 1'b0;
            lat_legal    <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            Ack0         <= 1'b0;
            Ack1         <= 1'b0;
            RData        <= '0;
            Err          <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Ack0 <= 1'b0;
                    Ack1 <= 1'b0;
                    if (Req0 || Req1) begin
                        state        <= ST_ACCESS;
                        gnt_id       <= win;
                        last_grant   <= win;
                        lat_legal    <= sel_legal;
                        mem_rd_q     <= sel_legal && !sel_write;
                        mem_wr_q     <= sel_legal && sel_write;
                        MemAddress   <= {{(32 - IDX_W){1'b0}}, sel_addr[IDX_W+1:2]};
                        MemWriteData <= sel_wdata;
                    end
                end
                ST_ACCESS: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    RData    <= mem_rd_q ? MemReadData : 32'h0;
                    Err      <= ~lat_legal;
                    Ack0     <= ~gnt_id;
                    Ack1     <= gnt_id;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    Ack0  <= 1'b0;
                    Ack1  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Ack0  <= 1'b0;
                    Ack1  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and memory strobes; a write is never allowed to reach memory during reset.
    always_comb begin
        Busy     = (state != ST_IDLE);
        MemRead  = mem_rd_q;
        MemWrite = mem_wr_q & ~RST;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural memory model.
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Req0, Req1, Write0, Write1;
    logic [31:0] Addr0, Addr1, WData0, WData1;
    logic        Ack0, Ack1, Err, Busy, MemRead, MemWrite;
    logic [31:0] RData, MemAddress, MemWriteData, MemReadData;

    logic [31:0] mem     [0:127] = '{default: 32'h0};
    logic [31:0] ref_mem [0:127] = '{default: 32'h0};

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .Req0(Req0), .Req1(Req1), .Write0(Write0), .Write1(Write1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Err(Err), .Busy(Busy),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    always #5 CLK = ~CLK;

    // Memory attached to the DUT: combinational read, write at posedge.
    assign MemReadData = (MemAddress < 32'd128) ? mem[MemAddress[6:0]] : 32'h0;
    always @(posedge CLK) begin
        if (MemWrite && MemAddress < 32'd128) mem[MemAddress[6:0]] <= MemWriteData;
    end

    task automatic drive_port(input int port, input bit req, input bit wr,
                              input logic [31:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            Req0 = req; Write0 = wr; Addr0 = addr; WData0 = wd;
        end else begin
            Req1 = req; Write1 = wr; Addr1 = addr; WData1 = wd;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // One access on an idle DUT; caller is at a negedge in IDLE.
    task automatic single_access(input int port, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] wd);
        bit          legal;
        logic [31:0] exp_rd;
        logic [1:0]  exp_ack;
        legal   = (addr[1:0] == 2'b00) && (addr < 32'd512);
        exp_rd  = (legal && !wr) ? ref_mem[int'(addr[8:2])] : 32'h0;
        exp_ack = (port == 0) ? 2'b10 : 2'b01;
        drive_port(port, 1'b1, wr, addr, wd);
        @(negedge CLK);
        n_cmp++;
        if ({MemRead, MemWrite} !== {legal && !wr, legal && wr}) begin
            n_bad++;
            $display("FAIL access_strobes addr=%h wr=%0d got rd/wr=%b%b want %b%b",
                     addr, wr, MemRead, MemWrite, legal && !wr, legal && wr);
        end
        if (legal) begin
            n_cmp++;
            if (MemAddress !== {25'h0, addr[8:2]}) begin
                n_bad++;
                $display("FAIL mem_address addr=%h got %h want %h", addr, MemAddress, {25'h0, addr[8:2]});
            end
        end
        if (legal && wr) begin
            n_cmp++;
            if (MemWriteData !== wd) begin
                n_bad++;
                $display("FAIL mem_wdata got %h want %h", MemWriteData, wd);
            end
        end
        n_cmp++;
        if ({Busy, Ack0, Ack1} !== 3'b100) begin
            n_bad++;
            $display("FAIL access_cycle busy/ack got %b want 100", {Busy, Ack0, Ack1});
        end
        @(negedge CLK);
        n_cmp++;
        if ({Ack0, Ack1} !== exp_ack) begin
            n_bad++;
            $display("FAIL ack_timing port=%0d got %b want %b", port, {Ack0, Ack1}, exp_ack);
        end
        n_cmp++;
        if (RData !== exp_rd || Err !== !legal) begin
            n_bad++;
            $display("FAIL result addr=%h got rdata=%h err=%b want rdata=%h err=%b",
                     addr, RData, Err, exp_rd, !legal);
        end
        drive_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
        if (legal && wr) ref_mem[int'(addr[8:2])] = wd;
        @(negedge CLK);
        n_cmp++;
        if ({Busy, Ack0, Ack1} !== 3'b000) begin
            n_bad++;
            $display("FAIL back_to_idle got %b want 000", {Busy, Ack0, Ack1});
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({Ack0, Ack1, Err, Busy, MemRead, MemWrite} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 000000", {Ack0, Ack1, Err, Busy, MemRead, MemWrite});
        end
        n_cmp++;
        if ({RData, MemAddress, MemWriteData} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_data got %h %h %h want 0", RData, MemAddress, MemWriteData);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write_read();
        single_access(0, 1'b1, 32'h10, 32'hDEADBEEF);
        n_cmp++;
        if (mem[4] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_commit got %h want deadbeef", mem[4]);
        end
        single_access(1, 1'b0, 32'h10, 32'h0);
        single_access(1, 1'b1, 32'h14, 32'h12345678);
        single_access(0, 1'b1, 32'h1FC, 32'hA5A5_0001);
        single_access(0, 1'b0, 32'h1FC, 32'h0);
    endtask

    task automatic test_round_robin();
        int ack_port [4];
        int ack_cyc  [4];
        int n_ack;
        int cyc;
        logic [31:0] exp_rd;
        do_reset();
        Write0 = 1'b0; Addr0 = 32'h10; WData0 = 32'h0;
        Write1 = 1'b0; Addr1 = 32'h14; WData1 = 32'h0;
        Req0 = 1'b1; Req1 = 1'b1;
        n_ack = 0;
        cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (Ack0 && Ack1) begin
                n_cmp++; n_bad++;
                $display("FAIL rr_double_ack cycle=%0d got both want one", cyc);
            end else if (Ack0 || Ack1) begin
                ack_port[n_ack] = Ack1 ? 1 : 0;
                ack_cyc[n_ack]  = cyc;
                exp_rd = Ack1 ? ref_mem[5] : ref_mem[4];
                n_cmp++;
                if (RData !== exp_rd || Err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rr_rdata got %h err=%b want %h err=0", RData, Err, exp_rd);
                end
                n_ack++;
                if (n_ack == 4) begin
                    Req0 = 1'b0; Req1 = 1'b0;
                end
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        n_cmp++;
        if (n_ack != 4) begin
            n_bad++;
            $display("FAIL rr_ack_count got %0d want 4", n_ack);
        end
        for (int i = 0; i < n_ack; i++) begin
            n_cmp++;
            if (ack_port[i] != (i % 2) || ack_cyc[i] != 2 + 3 * i) begin
                n_bad++;
                $display("FAIL rr_order idx=%0d got port=%0d cyc=%0d want port=%0d cyc=%0d",
                         i, ack_port[i], ack_cyc[i], i % 2, 2 + 3 * i);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_illegal();
        int diffs;
        single_access(0, 1'b0, 32'h202, 32'h0);
        single_access(1, 1'b1, 32'h200, 32'hFFFF_FFFF);
        single_access(0, 1'b1, 32'h8000_0010, 32'h0BAD_0BAD);
        single_access(1, 1'b0, 32'h0000_0011, 32'h0);
        diffs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
        n_cmp++;
        if (diffs != 0) begin
            n_bad++;
            $display("FAIL illegal_mem_untouched got %0d differing words want 0", diffs);
        end
    endtask

    task automatic test_reset_abort();
        drive_port(0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
        @(negedge CLK);
        n_cmp++;
        if (MemWrite !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre_write got %b want 1", MemWrite);
        end
        RST = 1'b1;
        #1;
        n_cmp++;
        if (MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_write_gate got %b want 0", MemWrite);
        end
        @(negedge CLK);
        n_cmp++;
        if ({Busy, Ack0, Ack1} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_idle busy/ack got %b want 000", {Busy, Ack0, Ack1});
        end
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({Busy, Ack0, Ack1} !== 3'b000 || mem[8] !== ref_mem[8]) begin
            n_bad++;
            $display("FAIL abort_no_ack got busy/ack=%b mem=%h want 000 mem=%h",
                     {Busy, Ack0, Ack1}, mem[8], ref_mem[8]);
        end
        single_access(1, 1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_back_to_back();
        int acks [2];
        int n_ack;
        int cyc;
        drive_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        n_ack = 0;
        cyc = 0;
        while (n_ack < 2 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (Ack1) begin
                n_cmp++; n_bad++;
                $display("FAIL b2b_wrong_port got Ack1 want Ack0 only");
            end
            if (Ack0) begin
                acks[n_ack] = cyc;
                n_ack++;
                if (n_ack == 2) drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (n_ack != 2 || acks[0] != 2 || acks[1] != 5) begin
            n_bad++;
            $display("FAIL b2b_timing got %0d acks at %0d,%0d want 2 acks at 2,5",
                     n_ack, acks[0], acks[1]);
        end
        @(negedge CLK);
    endtask

    task automatic test_random();
        int diffs;
        int port;
        bit wr;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            port = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: addr = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
                1: addr = 32'h200 + (32'($urandom_range(0, 1000)) << 2);
                2: addr = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
                default: addr = 32'($urandom_range(0, 127)) << 2;
            endcase
            single_access(port, wr, addr, $urandom);
        end
        diffs = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
        n_cmp++;
        if (diffs != 0) begin
            n_bad++;
            $display("FAIL random_mem_contents got %0d differing words want 0", diffs);
        end
    endtask

    initial begin
        RST = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0; Write0 = 1'b0; Write1 = 1'b0;
        Addr0 = 32'h0; Addr1 = 32'h0; WData0 = 32'h0; WData1 = 32'h0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and access sequencer for the single-port 128-word data memory. It sits between the memory and two masters: port 0 is the CPU MEM stage, port 1 is the loader/debug port. It grants the memory round-robin, converts byte addresses to word indices, and rejects misaligned or out-of-range accesses. It returns a registered read result with a one-cycle acknowledge pulse to the granted requester.

## Interface
- DEPTH, 128: memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH-4.
- IDX_W, 7: width of the word index, log2(DEPTH).

- CLK  in  1: clock; all state updates on posedge.
- RST  in  1: reset, synchronous, active-high.
- Req0 / Req1  in  1: access request; held high by the requester until its Ack.
- Write0 / Write1  in  1: 1 = write, 0 = read; held stable while Req is high.
- Addr0 / Addr1  in  32: byte address; held stable while Req is high.
- WData0 / WData1  in  32: write data; held stable while Req is high.
- Ack0 / Ack1  out  1: one-cycle completion pulse to the respective requester.
- RData  out  32: read result; valid in the Ack cycle.
- Err  out  1: access rejected; valid in the Ack cycle.
- Busy  out  1: high whenever the state is not IDLE.
- MemRead  out  1: read enable to the memory.
- MemWrite  out  1: write enable to the memory.
- MemAddress  out  32: word index, zero-extended from IDX_W bits.
- MemWriteData  out  32: data to the memory.
- MemReadData  in  32: combinational read data from the memory.

## Operation
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE. There are no other transitions except reset.
- IDLE:
  - If no Req is high, stay in IDLE.
  - Otherwise arbitrate. With one requester, grant it. With both, grant the port that was not granted last (last_grant).
  - At the edge, latch the winner's id, Write, Addr and WData, update last_grant, and go to ACCESS.
- Legality check on the latched address: illegal if Addr[1:0] != 0 or Addr >= 4*DEPTH.
- ACCESS, legal address:
  - MemAddress = Addr[IDX_W+1:2] and MemWriteData = latched WData.
  - Read: MemRead = 1. At the closing edge, RData <= MemReadData and Err <= 0.
  - Write: MemWrite = 1; the memory commits at the closing edge. RData <= 0 and Err <= 0.
- ACCESS, illegal address: MemRead = MemWrite = 0, RData <= 0, Err <= 1.
- After ACCESS, go to RESP.
- RESP:
  - Ack of the granted port = 1 for exactly this cycle.
  - RData and Err hold their registered values until the next ACCESS completes.
  - Go to IDLE unconditionally.
- MemRead and MemWrite are 0 in IDLE and RESP.
- MemAddress and MemWriteData hold their latched values outside ACCESS; they are 0 after reset.
- MemWrite is gated with !RST, so no memory write occurs in a cycle where RST is high.
- Width rules: the index is taken from Addr[IDX_W+1:2]. Upper address bits take part only in the range check and are never truncated silently.

## Timing
- Reset values: state = IDLE, last_grant = 1 (port 0 wins the first tie), Ack0 = Ack1 = 0, Err = 0, RData = 0, Busy = 0, MemRead = MemWrite = 0, MemAddress = MemWriteData = 0.
- Latency:
  - Req sampled high at edge E (state IDLE).
  - ACCESS runs in cycle E+1.
  - Ack is high in cycle E+2.
  - State is IDLE again at cycle E+3.
- Throughput: one access per 3 cycles under continuous requests.
- Handshake: the requester drops Req in the cycle after it sees Ack. A Req still high in IDLE after its Ack counts as a new request.
- A request arriving while Busy is high waits; it is sampled at the first IDLE edge.
- Simultaneous requests: grants alternate 0,1,0,1… When both stay asserted, neither port waits more than one access.
- Reset mid-operation: RST high in ACCESS or RESP forces IDLE at the edge. No Ack is issued, no memory write occurs, and the aborted request is not retried automatically (the requester still holds Req, so it is re-arbitrated).

## Test plan
- Reset, then Req0 writes 0xDEADBEEF to byte address 0x10 -> MemWrite = 1 with MemAddress = 4 in the ACCESS cycle; Ack0 two cycles after the request edge; Err = 0.
- Req1 reads byte address 0x10 after that write -> Ack1 in cycle E+2 with RData = 0xDEADBEEF, Err = 0; Ack0 stays 0.
- Req0 and Req1 both held high for 4 accesses from reset -> grant order 0,1,0,1; the Ack pulses are 3 cycles apart.
- Read of Addr = 0x202 (misaligned) and write of Addr = 0x200 (out of range) -> MemRead/MemWrite never asserted; Ack with Err = 1 and RData = 0; memory contents unchanged.
- RST asserted during the ACCESS cycle of a write to 0x20 -> no Ack; a later read of 0x20 returns the old value (0); state is IDLE one cycle after RST.
- Req0 still high in the IDLE cycle after Ack0 -> treated as a new request: a second ACCESS followed by a second Ack0 three cycles after the first.
